// File: rtl/psr_cond_unit.sv
// PSR flag register, one-deep interrupt shadow and CR-16 condition evaluation.
// Optional build macro COND_BYPASS_EN: cond_true evaluates the PSR next-state value.
module psr_cond_unit #(
   parameter int DATA_WIDTH  = 16,
   parameter int FLAG_MASK_W = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   alu_c,
   input  logic                   alu_l,
   input  logic                   alu_f,
   input  logic                   alu_z,
   input  logic                   alu_n,
   input  logic [FLAG_MASK_W-1:0] flag_we,
   input  logic                   psr_wr,
   input  logic [DATA_WIDTH-1:0]  psr_din,
   input  logic                   save,
   input  logic                   restore,
   input  logic [3:0]             cond,
   output logic [DATA_WIDTH-1:0]  psr_dout,
   output logic                   cond_true,
   output logic                   shadow_valid,
   output logic                   restore_err
);

   // Internal flag vector order is {N,Z,F,L,C}, matching flag_we.
   localparam int NF = 5;

   logic [NF-1:0] flags_r;
   logic [NF-1:0] shadow_r;
   logic          shadow_valid_r;
   logic          restore_err_r;
   logic [NF-1:0] flags_nxt_s;
   logic [NF-1:0] alu_vec_s;
   logic [NF-1:0] eval_flags_s;

   function automatic logic eval_cond(input logic [3:0] cc, input logic [NF-1:0] f);
      logic c_v, l_v, fl_v, z_v, n_v, res_v;
      c_v  = f[0];
      l_v  = f[1];
      fl_v = f[2];
      z_v  = f[3];
      n_v  = f[4];
      case (cc)
         4'b0000: res_v = z_v;
         4'b0001: res_v = ~z_v;
         4'b0010: res_v = c_v;
         4'b0011: res_v = ~c_v;
         4'b0100: res_v = l_v;
         4'b0101: res_v = ~l_v;
         4'b0110: res_v = n_v;
         4'b0111: res_v = ~n_v;
         4'b1000: res_v = fl_v;
         4'b1001: res_v = ~fl_v;
         4'b1010: res_v = ~l_v & ~z_v;
         4'b1011: res_v = l_v | z_v;
         4'b1100: res_v = ~n_v & ~z_v;
         4'b1101: res_v = n_v | z_v;
         4'b1110: res_v = 1'b1;
         4'b1111: res_v = 1'b0;
         default: res_v = 1'b0;
      endcase
      return res_v;
   endfunction

   assign alu_vec_s = {alu_n, alu_z, alu_f, alu_l, alu_c};

   // PSR next-state: restore beats psr_wr beats per-flag ALU writes.
   always_comb begin
      flags_nxt_s = flags_r;
      if (restore) begin
         if (shadow_valid_r) begin
            flags_nxt_s = shadow_r;
         end else begin
            flags_nxt_s = flags_r;
         end
      end else if (psr_wr) begin
         flags_nxt_s = {psr_din[7], psr_din[6], psr_din[5], psr_din[2], psr_din[0]};
      end else begin
         for (int i = 0; i < NF; i++) begin
            if (flag_we[i]) begin
               flags_nxt_s[i] = alu_vec_s[i];
            end else begin
               flags_nxt_s[i] = flags_r[i];
            end
         end
      end
   end

   // PSR, shadow and restore error state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flags_r        <= 5'b00000;
         shadow_r       <= 5'b00000;
         shadow_valid_r <= 1'b0;
         restore_err_r  <= 1'b0;
      end else begin
         flags_r       <= flags_nxt_s;
         restore_err_r <= restore & ~shadow_valid_r;
         if (restore) begin
            shadow_valid_r <= 1'b0;
         end else if (save) begin
            shadow_r       <= flags_r;
            shadow_valid_r <= 1'b1;
         end else begin
            shadow_r       <= shadow_r;
            shadow_valid_r <= shadow_valid_r;
         end
      end
   end

   // Place flags at their architectural PSR bit positions.
   always_comb begin
      psr_dout    = {DATA_WIDTH{1'b0}};
      psr_dout[0] = flags_r[0];
      psr_dout[2] = flags_r[1];
      psr_dout[5] = flags_r[2];
      psr_dout[6] = flags_r[3];
      psr_dout[7] = flags_r[4];
   end

`ifdef COND_BYPASS_EN
   assign eval_flags_s = flags_nxt_s;
`else
   assign eval_flags_s = flags_r;
`endif

   assign cond_true    = eval_cond(cond, eval_flags_s);
   assign shadow_valid = shadow_valid_r;
   assign restore_err  = restore_err_r;

endmodule

// File: doc/psr_cond_unit.md
Name: psr_cond_unit

Overview:
- Consumer end of the ALU flag interface. Latches the C, L, F, Z, N flags produced each cycle into the processor status register (PSR).
- Evaluates the 4-bit CR-16 condition code for Bcond, Jcond and Scond instructions.
- Provides a one-deep shadow copy of the PSR for interrupt entry and return, plus a software PSR read/write path for LPR/SPR.
- Sits between the ALU and the control FSM / PC logic.

Parameters:
DATA_WIDTH, 16, width of the PSR read/write bus
FLAG_MASK_W, 5, width of the per-flag write mask; fixed order {N,Z,F,L,C}

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
alu_c, alu_l, alu_f, alu_z, alu_n  input  1 each  flags from the ALU this cycle
flag_we  input  5  per-flag write enable {N,Z,F,L,C}
psr_wr  input  1  load PSR flag bits from psr_din (LPR)
psr_din  input  DATA_WIDTH  software PSR value
save  input  1  copy PSR to shadow (interrupt entry)
restore  input  1  copy shadow to PSR (interrupt return)
cond  input  4  condition code to evaluate
psr_dout  output  DATA_WIDTH  current PSR; C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7, all other bits 0
cond_true  output  1  result of evaluating cond
shadow_valid  output  1  shadow holds a saved PSR
restore_err  output  1  one-cycle pulse, registered: restore requested with no valid shadow

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - PSR flags = 0; shadow = 0; shadow_valid = 0; restore_err = 0.
  - psr_dout = 0. cond_true then follows the table for all-zero flags.
- PSR next-state priority, highest first: reset, restore, psr_wr, flag_we. Only the highest active source updates the PSR in a given cycle.
- restore:
  - If shadow_valid=1: PSR <= shadow; shadow_valid <= 0.
  - If shadow_valid=0: PSR unchanged; restore_err = 1 for the next cycle only.
- psr_wr: PSR flags <= psr_din bits 0, 2, 5, 6, 7. All other bits are ignored.
- flag_we: each flag whose enable bit is 1 takes its alu_* value. Flags whose enable bit is 0 hold.
- save:
  - Shadow <= registered PSR (value before this cycle's update); shadow_valid <= 1.
  - A save while shadow_valid=1 overwrites the shadow (one-deep, no error).
  - save and restore in the same cycle: restore takes effect, save is ignored, shadow_valid <= 0.
- psr_dout is combinational from the PSR register. Zero-latency read of the registered value.
- cond_true is combinational from cond and the evaluated flag set; zero latency. Table:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111: 0 (never)
- No handshake; all inputs are single-cycle strobes, valid whenever asserted.

Optional Feature:
- Macro COND_BYPASS_EN.
- Defined: cond_true evaluates the PSR next-state value (full priority mux above, excluding reset), so a compare and a branch issued in the same cycle resolve correctly.
- Undefined: cond_true evaluates the registered PSR only; a branch sees flags one cycle after the compare.
- psr_dout is the registered value in both builds.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with flag_we=5'h1F and all alu_*=1 -> psr_dout=16'h0000, shadow_valid=0, cond=1110 gives cond_true=1, cond=0000 gives cond_true=0.
- Masked write: flag_we=5'b00001, alu_c=1, alu_z=1 -> next cycle psr_dout=16'h0001. Then flag_we=5'b01000, alu_z=1 -> psr_dout=16'h0041. Then EQ=1, CS=1, LO=0.
- Full table sweep: for each of the 32 flag combinations, load the PSR via psr_wr and step cond through 0..15 -> cond_true matches the table. E.g. psr_din=16'h0004 (L=1): HI=1, HS=1, LO=0.
- Save/restore: PSR=16'h00C0, save; then psr_wr with 16'h0001; then restore -> psr_dout=16'h00C0 and shadow_valid=0. A second restore -> psr_dout unchanged and restore_err high for exactly 1 cycle.
- Priority: in one cycle assert restore (shadow=16'h0020), psr_wr with 16'h0001, flag_we=5'h1F with all alu_*=1, and save -> psr_dout=16'h0020, shadow_valid=0.
- Bypass: PSR=0, flag_we=5'b01000, alu_z=1, cond=0000 in the same cycle -> cond_true=1 that cycle with COND_BYPASS_EN defined. Without the macro, cond_true=0 that cycle and 1 the next.
